capturador_pin: RTL and testbench

Keypad PIN capture stage feeding the parking-gate controller's `Pin` input. Collects BCD keypad digits while a vehicle is present and assembles them into an 8-bit PIN, most-significant digit first. Presents the PIN for a fixed number of cycles, then returns `Pin` to the idle code. Supports a clear key and an optional inter-digit timeout.

---
 rtl/capturador_pkg.sv | 29 ++
 rtl/contador_espera.sv | 40 ++++
 rtl/capturador_pin.sv | 195 +++++++++++++++++++
 tb/tb_capturador_pin.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/capturador_pkg.sv
// rtl/capturador_pkg.sv - shared types and constants for the keypad PIN capture stage
//
// Purpose: state encoding, key codes and the default idle PIN code used by
//          capturador_pin and its helpers.
// Contents: estado_t (ESPERA, CAPTURA, PRESENTA), TECLA_BORRAR,
//           TECLA_MAX_DIGITO, PIN_IDLE_DEFECTO, key classification helpers.
package capturador_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CAPTURA  = 2'd1,
    PRESENTA = 2'd2
  } estado_t;

  localparam logic [3:0] TECLA_BORRAR     = 4'hA;
  localparam logic [3:0] TECLA_MAX_DIGITO = 4'h9;

  // All-ones can never be a BCD PIN, so it is safe as the idle marker.
  localparam logic [7:0] PIN_IDLE_DEFECTO = 8'hFF;

  function automatic logic es_digito(input logic [3:0] tecla);
    return tecla <= TECLA_MAX_DIGITO;
  endfunction

  function automatic logic es_invalida(input logic [3:0] tecla);
    return tecla > TECLA_BORRAR;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - loadable down-counter with clear and terminal-count flag
//
// Purpose: counts down from a loaded value while enabled; fin is high in any
//          enabled cycle in which the count has reached zero.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   cargar     load valor on the next edge
//   valor      load value
//   habilitar  count down on the next edge (saturates at zero)
//   borrar     force the count to zero (wins over cargar)
//   fin        terminal-count flag (habilitar and count == 0)
module contador_espera #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor,
  input  logic             habilitar,
  input  logic             borrar,
  output logic             fin
);

  logic [ANCHO-1:0] cuenta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (borrar) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= valor;
    end else if (habilitar && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign fin = habilitar && (cuenta == '0);

endmodule

// File: rtl/capturador_pin.sv
// rtl/capturador_pin.sv - keypad PIN capture stage for the parking-gate controller
//
// Purpose: collects BCD digits while a vehicle is present, assembles them MSD
//          first and presents the PIN for HOLD_CYCLES cycles, then returns Pin
//          to PIN_IDLE. Optional inter-digit timeout when CAPTURADOR_TIMEOUT_EN
//          is defined; without it Expirado is tied low.
// Ports:
//   Clk, Reset      clock, asynchronous active-high reset
//   Vehiculo        vehicle present, enables entry
//   Tecla           key code (0-9 digit, A clear, B-F invalid)
//   Tecla_valida    Tecla sampled this cycle
//   Pin             assembled PIN while presenting, else PIN_IDLE
//   Pin_listo       high while Pin carries an assembled PIN
//   Cuenta_digitos  digits captured in the current entry
//   Tecla_error     one-cycle pulse after an invalid code in CAPTURA
//   Expirado        one-cycle pulse after the timeout discards an entry
module capturador_pin
  import capturador_pkg::*;
#(
  parameter int                  DIGITS         = 2,
  parameter logic [4*DIGITS-1:0] PIN_IDLE       = PIN_IDLE_DEFECTO,
  parameter int                  HOLD_CYCLES    = 4,
  parameter int                  TIMEOUT_CYCLES = 50
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Vehiculo,
  input  logic [3:0]                   Tecla,
  input  logic                         Tecla_valida,
  output logic [4*DIGITS-1:0]          Pin,
  output logic                         Pin_listo,
  output logic [$clog2(DIGITS+1)-1:0]  Cuenta_digitos,
  output logic                         Tecla_error,
  output logic                         Expirado
);

  localparam int ANCHO_PIN    = 4 * DIGITS;
  localparam int ANCHO_CUENTA = $clog2(DIGITS + 1);
  localparam int ANCHO_HOLD   = $clog2(HOLD_CYCLES + 1);

  estado_t                 estado_q, estado_n;
  logic [ANCHO_PIN-1:0]    shift_q, shift_n;
  logic [ANCHO_CUENTA-1:0] cuenta_n;
  logic                    error_n;
  logic                    descartar;
  logic                    cargar_tiempo;
  logic                    vencido;
  logic                    fin_hold;
  logic                    cargar_hold;

  logic tecla_digito;
  logic tecla_borrar;
  logic tecla_invalida;
  logic ultimo_digito;

  assign tecla_digito   = Tecla_valida && es_digito(Tecla);
  assign tecla_borrar   = Tecla_valida && (Tecla == TECLA_BORRAR);
  assign tecla_invalida = Tecla_valida && es_invalida(Tecla);
  assign ultimo_digito  = (Cuenta_digitos == ANCHO_CUENTA'(DIGITS - 1));

  // State register plus all registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado_q       <= ESPERA;
      shift_q        <= '0;
      Cuenta_digitos <= '0;
      Pin            <= PIN_IDLE;
      Pin_listo      <= 1'b0;
      Tecla_error    <= 1'b0;
    end else begin
      estado_q       <= estado_n;
      shift_q        <= shift_n;
      Cuenta_digitos <= cuenta_n;
      Pin            <= (estado_n == PRESENTA) ? shift_n : PIN_IDLE;
      Pin_listo      <= (estado_n == PRESENTA);
      Tecla_error    <= error_n;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_n = estado_q;
    unique case (estado_q)
      ESPERA: begin
        if (Vehiculo) estado_n = CAPTURA;
      end
      CAPTURA: begin
        if (!Vehiculo) begin
          estado_n = ESPERA;
        end else if (tecla_digito && ultimo_digito) begin
          estado_n = PRESENTA;
        end
      end
      PRESENTA: begin
        // Vehiculo is only consulted once the hold has run out.
        if (fin_hold) estado_n = Vehiculo ? CAPTURA : ESPERA;
      end
      default: estado_n = ESPERA;
    endcase
  end

  // Datapath / output next values. Priority inside CAPTURA:
  // vehicle gone > digit > clear > invalid key / timeout.
  always_comb begin
    shift_n       = shift_q;
    cuenta_n      = Cuenta_digitos;
    error_n       = 1'b0;
    descartar     = 1'b0;
    cargar_tiempo = 1'b0;
    unique case (estado_q)
      ESPERA: begin
        shift_n  = '0;
        cuenta_n = '0;
      end
      CAPTURA: begin
        if (!Vehiculo) begin
          shift_n  = '0;
          cuenta_n = '0;
        end else if (tecla_digito) begin
          shift_n       = (shift_q << 4) | ANCHO_PIN'(Tecla);
          cuenta_n      = Cuenta_digitos + 1'b1;
          cargar_tiempo = 1'b1;
        end else if (tecla_borrar) begin
          shift_n  = '0;
          cuenta_n = '0;
        end else begin
          error_n = tecla_invalida;
          if (vencido) begin
            descartar = 1'b1;
            shift_n   = '0;
            cuenta_n  = '0;
          end
        end
      end
      PRESENTA: begin
        if (fin_hold) begin
          shift_n  = '0;
          cuenta_n = '0;
        end
      end
      default: begin
        shift_n  = '0;
        cuenta_n = '0;
      end
    endcase
  end

  // Hold timer: loaded with HOLD_CYCLES-1 on the completing edge, so the
  // terminal flag appears on the HOLD_CYCLES-th edge after entry.
  assign cargar_hold = (estado_q != PRESENTA) && (estado_n == PRESENTA);

  contador_espera #(
    .ANCHO(ANCHO_HOLD)
  ) u_hold (
    .clk      (Clk),
    .rst      (Reset),
    .cargar   (cargar_hold),
    .valor    (ANCHO_HOLD'(HOLD_CYCLES - 1)),
    .habilitar(estado_q == PRESENTA),
    .borrar   (1'b0),
    .fin      (fin_hold)
  );

`ifdef CAPTURADOR_TIMEOUT_EN
  localparam int ANCHO_TIEMPO = $clog2(TIMEOUT_CYCLES + 1);

  // Restarted by every accepted digit; only runs with a partial entry.
  contador_espera #(
    .ANCHO(ANCHO_TIEMPO)
  ) u_tiempo (
    .clk      (Clk),
    .rst      (Reset),
    .cargar   (cargar_tiempo),
    .valor    (ANCHO_TIEMPO'(TIMEOUT_CYCLES - 1)),
    .habilitar((estado_q == CAPTURA) && (Cuenta_digitos != '0)),
    .borrar   (estado_q != CAPTURA),
    .fin      (vencido)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Expirado <= 1'b0;
    end else begin
      Expirado <= descartar;
    end
  end
`else
  logic unused_tiempo;

  assign vencido       = 1'b0;
  assign Expirado      = 1'b0;
  assign unused_tiempo = cargar_tiempo ^ descartar ^ (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_capturador_pin.sv
// tb/tb_capturador_pin.sv - self-checking bench for capturador_pin
module tb_capturador_pin;

  localparam int DIGITS = 2;
  localparam int HOLD   = 4;
  localparam int TMO    = 50;
`ifdef CAPTURADOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int F_ESPERA   = 0;
  localparam int F_CAPTURA  = 1;
  localparam int F_PRESENTA = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Vehiculo;
  logic [3:0] Tecla;
  logic       Tecla_valida;
  logic [7:0] Pin;
  logic       Pin_listo;
  logic [1:0] Cuenta_digitos;
  logic       Tecla_error;
  logic       Expirado;

  int n_comp   = 0;
  int n_fallos = 0;

  // Reference model: entry as a list of digits plus simple cycle counters.
  int fase;
  int dig[$];
  int restante;
  int ocioso;
  bit m_err;
  bit m_exp;

  capturador_pin dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Vehiculo      (Vehiculo),
    .Tecla         (Tecla),
    .Tecla_valida  (Tecla_valida),
    .Pin           (Pin),
    .Pin_listo     (Pin_listo),
    .Cuenta_digitos(Cuenta_digitos),
    .Tecla_error   (Tecla_error),
    .Expirado      (Expirado)
  );

  always #5 Clk = ~Clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [7:0] pin_esperado();
    int v;
    v = 0;
    if (fase != F_PRESENTA) return 8'hFF;
    foreach (dig[i]) v = v * 16 + dig[i];
    return v[7:0];
  endfunction

  task automatic modelo_reset();
    fase = F_ESPERA;
    dig.delete();
    restante = 0;
    ocioso = 0;
    m_err = 1'b0;
    m_exp = 1'b0;
  endtask

  task automatic modelo_paso(input bit v, input bit kv, input int k);
    m_err = 1'b0;
    m_exp = 1'b0;
    case (fase)
      F_ESPERA: begin
        dig.delete();
        if (v) fase = F_CAPTURA;
      end
      F_CAPTURA: begin
        if (!v) begin
          dig.delete();
          fase = F_ESPERA;
        end else if (kv && k <= 9) begin
          dig.push_back(k);
          ocioso = 0;
          if (dig.size() == DIGITS) begin
            fase = F_PRESENTA;
            restante = HOLD;
          end
        end else if (kv && k == 10) begin
          dig.delete();
        end else begin
          if (kv) m_err = 1'b1;
          if (TMO_EN && dig.size() > 0) begin
            ocioso++;
            if (ocioso == TMO) begin
              dig.delete();
              m_exp = 1'b1;
            end
          end
        end
      end
      default: begin
        restante--;
        if (restante == 0) begin
          dig.delete();
          fase = v ? F_CAPTURA : F_ESPERA;
        end
      end
    endcase
  endtask

  task automatic revisar(input string tag);
    comprobar({tag, ".pin"}, 32'(Pin), 32'(pin_esperado()));
    comprobar({tag, ".listo"}, 32'(Pin_listo), 32'(fase == F_PRESENTA));
    comprobar({tag, ".cuenta"}, 32'(Cuenta_digitos), 32'(dig.size()));
    comprobar({tag, ".error"}, 32'(Tecla_error), 32'(m_err));
    comprobar({tag, ".expirado"}, 32'(Expirado), 32'(m_exp));
  endtask

  task automatic ciclo(input string tag, input bit v, input bit kv, input logic [3:0] k);
    Vehiculo = v;
    Tecla_valida = kv;
    Tecla = k;
    @(posedge Clk);
    modelo_paso(v, kv, int'(k));
    @(negedge Clk);
    revisar(tag);
  endtask

  task automatic teclas(input string tag, input logic [3:0] a, input logic [3:0] b);
    ciclo(tag, 1'b1, 1'b1, a);
    ciclo(tag, 1'b1, 1'b1, b);
  endtask

  initial begin
    Reset = 1'b1;
    Vehiculo = 1'b0;
    Tecla_valida = 1'b0;
    Tecla = 4'h0;
    modelo_reset();
    @(negedge Clk);
    @(negedge Clk);
    revisar("reset");
    Reset = 1'b0;

    // Keys 0, 8 -> 08 held for HOLD cycles.
    ciclo("entrar", 1'b1, 1'b0, 4'h0);
    teclas("pin08", 4'h0, 4'h8);
    comprobar("pin08.valor", 32'(Pin), 32'h08);
    comprobar("pin08.listo_alto", 32'(Pin_listo), 32'd1);
    repeat (HOLD - 1) ciclo("hold08", 1'b1, 1'b0, 4'h0);
    comprobar("pin08.ultimo_ciclo", 32'(Pin), 32'h08);
    ciclo("fin08", 1'b1, 1'b0, 4'h0);
    comprobar("pin08.idle", 32'(Pin), 32'hFF);

    // Keys 3, A, 1, 2 -> 12, clear zeroes the count.
    ciclo("k3", 1'b1, 1'b1, 4'h3);
    ciclo("borrar", 1'b1, 1'b1, 4'hA);
    comprobar("borrar.cuenta", 32'(Cuenta_digitos), 32'd0);
    teclas("pin12", 4'h1, 4'h2);
    comprobar("pin12.valor", 32'(Pin), 32'h12);
    // Clear and invalid keys during the hold are ignored.
    ciclo("hold_borrar", 1'b1, 1'b1, 4'hA);
    ciclo("hold_inval", 1'b1, 1'b1, 4'hE);
    comprobar("hold.sin_error", 32'(Tecla_error), 32'd0);
    repeat (HOLD - 2) ciclo("hold12", 1'b1, 1'b0, 4'h0);

    // Invalid key C pulses Tecla_error, then 5, 5.
    ciclo("tecla_c", 1'b1, 1'b1, 4'hC);
    comprobar("tecla_c.error", 32'(Tecla_error), 32'd1);
    comprobar("tecla_c.cuenta", 32'(Cuenta_digitos), 32'd0);
    teclas("pin55", 4'h5, 4'h5);
    comprobar("pin55.valor", 32'(Pin), 32'h55);
    repeat (HOLD) ciclo("hold55", 1'b1, 1'b0, 4'h0);

    // Key 7 then vehicle leaves (with a simultaneous key).
    ciclo("k7", 1'b1, 1'b1, 4'h7);
    ciclo("salida", 1'b0, 1'b1, 4'h4);
    comprobar("salida.cuenta", 32'(Cuenta_digitos), 32'd0);
    ciclo("espera", 1'b0, 1'b1, 4'h2);
    ciclo("vuelve", 1'b1, 1'b0, 4'h0);
    teclas("pin01", 4'h0, 4'h1);
    comprobar("pin01.valor", 32'(Pin), 32'h01);
    // Vehicle leaving during the hold does not shorten it.
    repeat (HOLD) ciclo("hold01", 1'b0, 1'b0, 4'h0);
    ciclo("reentrar", 1'b1, 1'b0, 4'h0);

    // Inter-digit timeout.
    ciclo("k9", 1'b1, 1'b1, 4'h9);
    repeat (TMO) ciclo("ocioso", 1'b1, 1'b0, 4'h0);
    comprobar("timeout.expirado", 32'(Expirado), 32'(TMO_EN));
    comprobar("timeout.cuenta", 32'(Cuenta_digitos), TMO_EN ? 32'd0 : 32'd1);
    comprobar("timeout.pin", 32'(Pin), 32'hFF);
    ciclo("tras_timeout", 1'b1, 1'b1, 4'hA);

    // Asynchronous reset during PRESENTA.
    teclas("pin66", 4'h6, 4'h6);
    comprobar("pin66.valor", 32'(Pin), 32'h66);
    #2;
    Reset = 1'b1;
    #1;
    comprobar("reset_async.pin", 32'(Pin), 32'hFF);
    comprobar("reset_async.listo", 32'(Pin_listo), 32'd0);
    comprobar("reset_async.cuenta", 32'(Cuenta_digitos), 32'd0);
    modelo_reset();
    @(negedge Clk);
    revisar("reset_async");
    Reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit v;
      bit kv;
      logic [3:0] k;
      v  = ($urandom_range(0, 29) != 0);
      kv = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) k = 4'(10 + $urandom_range(0, 5));
      else k = 4'($urandom_range(0, 9));
      ciclo("aleatorio", v, kv, k);
      if ($urandom_range(0, 99) == 0) begin
        repeat (TMO + 5) ciclo("aleatorio_ocioso", 1'b1, 1'b0, 4'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_comp, n_fallos);
    $finish;
  end

endmodule
